// File: rtl/wb_write_serializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_write_serializer
// Folds the two writeback slots onto one register-file write port, stalling
// M/W for one cycle when both slots need distinct writes.
// Rev 1.0
// ---------------------------------------------------------------------------
module wb_write_serializer #(
  parameter int RSTATUS_REG = 30,
  parameter int LINK_REG    = 31,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instruction_in_top,
  input  logic [31:0]      dataO_top,
  input  logic [31:0]      dataD_top,
  input  logic             ovf_in_top,
  input  logic [31:0]      instruction_in_bot,
  input  logic [31:0]      dataO_bot,
  input  logic [31:0]      dataD_bot,
  input  logic             ovf_in_bot,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             wb_stall,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_SETX  = 5'b10101;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  localparam logic [4:0] RSTATUS_ADDR = 5'(RSTATUS_REG);
  localparam logic [4:0] LINK_ADDR    = 5'(LINK_REG);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_DRAIN = 1'b1;

  // Returns {we, waddr, wdata} for one slot after overflow override and r0 suppression.
  function automatic logic [37:0] decode_slot(input logic [31:0] instr,
                                              input logic [31:0] o,
                                              input logic [31:0] d,
                                              input logic        ovf);
    logic        we;
    logic [4:0]  addr;
    logic [31:0] val;
    we   = 1'b0;
    addr = instr[26:22];
    val  = o;
    case (instr[31:27])
      OP_RTYPE: begin
        we = 1'b1;
        if (ovf) begin
          case (instr[6:2])
            ALU_ADD: begin addr = RSTATUS_ADDR; val = 32'd1; end
            ALU_SUB: begin addr = RSTATUS_ADDR; val = 32'd3; end
            ALU_MUL: begin addr = RSTATUS_ADDR; val = 32'd4; end
            ALU_DIV: begin addr = RSTATUS_ADDR; val = 32'd5; end
            default: ;
          endcase
        end
      end
      OP_ADDI: begin
        we = 1'b1;
        if (ovf) begin
          addr = RSTATUS_ADDR;
          val  = 32'd2;
        end
      end
      OP_LW: begin
        we  = 1'b1;
        val = d;
      end
      OP_JAL: begin
        we   = 1'b1;
        addr = LINK_ADDR;
      end
      OP_SETX: begin
        we   = 1'b1;
        addr = RSTATUS_ADDR;
        val  = {5'b0, instr[26:0]};
      end
      default: we = 1'b0;
    endcase
    if (addr == 5'd0) we = 1'b0;
    return {we, addr, val};
  endfunction

  logic [37:0] top_dec;
  logic [37:0] bot_dec;
  logic        top_we;
  logic        bot_we;
  logic [4:0]  top_addr;
  logic [4:0]  bot_addr;
  logic [31:0] top_data;
  logic [31:0] bot_data;
  logic        dual_write;

  always_comb begin
    top_dec = decode_slot(instruction_in_top, dataO_top, dataD_top, ovf_in_top);
    bot_dec = decode_slot(instruction_in_bot, dataO_bot, dataD_bot, ovf_in_bot);
    {top_we, top_addr, top_data} = top_dec;
    {bot_we, bot_addr, bot_data} = bot_dec;
    dual_write = top_we && bot_we && (top_addr != bot_addr);
  end

  logic [0:0]       state_q, state_d;
  logic [4:0]       hold_addr_q, hold_addr_d;
  logic [31:0]      hold_data_q, hold_data_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      hold_addr_q   <= 5'd0;
      hold_data_q   <= 32'd0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      hold_addr_q   <= hold_addr_d;
      hold_data_q   <= hold_data_d;
      stall_count_q <= stall_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    hold_addr_d   = hold_addr_q;
    hold_data_d   = hold_data_q;
    stall_count_d = stall_count_q;
    case (state_q)
      S_IDLE: begin
        if (dual_write) begin
          state_d     = S_DRAIN;
          hold_addr_d = bot_addr;
          hold_data_d = bot_data;
          if (stall_count_q != {CNT_W{1'b1}}) stall_count_d = stall_count_q + CNT_W'(1);
        end
      end
      S_DRAIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Reset gates the port directly so an asserted reset silences it within the cycle.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    wb_stall = 1'b0;
    if (!reset) begin
      if (state_q == S_DRAIN) begin
        rf_we    = 1'b1;
        rf_waddr = hold_addr_q;
        rf_wdata = hold_data_q;
      end else if (dual_write) begin
        rf_we    = 1'b1;
        rf_waddr = top_addr;
        rf_wdata = top_data;
        wb_stall = 1'b1;
      end else if (bot_we) begin
        rf_we    = 1'b1;
        rf_waddr = bot_addr;
        rf_wdata = bot_data;
      end else if (top_we) begin
        rf_we    = 1'b1;
        rf_waddr = top_addr;
        rf_wdata = top_data;
      end
    end
  end

  assign stall_count = stall_count_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_write_serializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_wb_write_serializer
// Directed stimulus with a queued scoreboard checked at each falling edge.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_wb_write_serializer;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [31:0]      instruction_in_top = '0, dataO_top = '0, dataD_top = '0;
  logic [31:0]      instruction_in_bot = '0, dataO_bot = '0, dataD_bot = '0;
  logic             ovf_in_top = 1'b0, ovf_in_bot = 1'b0;
  logic             rf_we;
  logic [4:0]       rf_waddr;
  logic [31:0]      rf_wdata;
  logic             wb_stall;
  logic [CNT_W-1:0] stall_count;

  wb_write_serializer #(.RSTATUS_REG(30), .LINK_REG(31), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .instruction_in_top(instruction_in_top), .dataO_top(dataO_top),
    .dataD_top(dataD_top), .ovf_in_top(ovf_in_top),
    .instruction_in_bot(instruction_in_bot), .dataO_bot(dataO_bot),
    .dataD_bot(dataD_bot), .ovf_in_bot(ovf_in_bot),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .wb_stall(wb_stall), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        stall;
    logic [1:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] aluop);
    return {5'b00000, rd, 15'b0, aluop, 2'b00};
  endfunction
  function automatic logic [31:0] itype(input logic [4:0] op, input logic [4:0] rd);
    return {op, rd, 22'b0};
  endfunction

  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [31:0] NOP    = 32'd0;

  task automatic check(input string nm, input string field, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, field, act, req);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.name, "we", 32'(rf_we), 32'(e.we));
      check(e.name, "stall", 32'(wb_stall), 32'(e.stall));
      check(e.name, "count", 32'(stall_count), 32'(e.cnt));
      if (e.we) begin
        check(e.name, "waddr", 32'(rf_waddr), 32'(e.addr));
        check(e.name, "wdata", rf_wdata, e.data);
      end
    end
  end

  // One cycle: apply inputs just after the rising edge, optionally pulse reset mid-cycle.
  task automatic drive(input string nm, input logic rst_v, input logic pulse,
                       input logic [31:0] ti, input logic [31:0] to, input logic [31:0] td, input logic tov,
                       input logic [31:0] bi, input logic [31:0] bo, input logic [31:0] bd, input logic bov,
                       input logic we, input logic [4:0] a, input logic [31:0] d,
                       input logic st, input logic [1:0] c);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst_v;
    instruction_in_top = ti; dataO_top = to; dataD_top = td; ovf_in_top = tov;
    instruction_in_bot = bi; dataO_bot = bo; dataD_bot = bd; ovf_in_bot = bov;
    if (pulse) begin
      #1;
      reset = 1'b1;
    end
    e.name = nm; e.we = we; e.addr = a; e.data = d; e.stall = st; e.cnt = c;
    exp_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Dual write presented while reset is held: port must stay silent.
    drive("in_reset", 1, 0, rtype(5'd1, 5'd0), 32'h11, 0, 0, rtype(5'd2, 5'd0), 32'h22, 0, 0,
          0, 0, 0, 0, 2'd0);
    drive("dual_top", 0, 0, rtype(5'd3, 5'd0), 32'd7, 0, 0, itype(OP_LW, 5'd4), 0, 32'd9, 0,
          1, 5'd3, 32'd7, 1, 2'd0);
    drive("dual_bot", 0, 0, rtype(5'd3, 5'd0), 32'd7, 0, 0, itype(OP_LW, 5'd4), 0, 32'd9, 0,
          1, 5'd4, 32'd9, 0, 2'd1);
    drive("same_dst", 0, 0, itype(OP_ADDI, 5'd5), 32'd1, 0, 0, rtype(5'd5, 5'd0), 32'd2, 0, 0,
          1, 5'd5, 32'd2, 0, 2'd1);
    drive("sub_ovf", 0, 0, rtype(5'd7, 5'd1), 32'hdead, 0, 1, NOP, 0, 0, 0,
          1, 5'd30, 32'd3, 0, 2'd1);
    drive("r0_jal", 0, 0, itype(OP_ADDI, 5'd0), 32'd5, 0, 0, itype(OP_JAL, 5'd9), 32'h40, 0, 0,
          1, 5'd31, 32'h40, 0, 2'd1);
    drive("setx_mul", 0, 0, {5'b10101, 27'h123}, 0, 0, 0, rtype(5'd6, 5'd6), 32'h99, 0, 1,
          1, 5'd30, 32'd4, 0, 2'd1);
    drive("no_write", 0, 0, NOP, 32'h1, 0, 0, {5'b11111, 27'h0}, 32'h2, 0, 0,
          0, 0, 0, 0, 2'd1);
    drive("rst_top", 0, 0, rtype(5'd1, 5'd0), 32'h11, 0, 0, rtype(5'd2, 5'd0), 32'h22, 0, 0,
          1, 5'd1, 32'h11, 1, 2'd1);
    drive("rst_drain", 0, 1, rtype(5'd1, 5'd0), 32'h11, 0, 0, rtype(5'd2, 5'd0), 32'h22, 0, 0,
          0, 0, 0, 0, 2'd0);
    drive("post_rst", 0, 0, NOP, 0, 0, 0, NOP, 0, 0, 0,
          0, 0, 0, 0, 2'd0);
    drive("post_single", 0, 0, rtype(5'd2, 5'd0), 32'h22, 0, 0, NOP, 0, 0, 0,
          1, 5'd2, 32'h22, 0, 2'd0);
    // Four back-to-back dual writes: the 2-bit counter tops out at 3.
    drive("sat1_top", 0, 0, rtype(5'd8, 5'd0), 32'd1, 0, 0, itype(OP_LW, 5'd9), 0, 32'h101, 0,
          1, 5'd8, 32'd1, 1, 2'd0);
    drive("sat1_bot", 0, 0, rtype(5'd8, 5'd0), 32'd1, 0, 0, itype(OP_LW, 5'd9), 0, 32'h101, 0,
          1, 5'd9, 32'h101, 0, 2'd1);
    drive("sat2_top", 0, 0, rtype(5'd8, 5'd0), 32'd2, 0, 0, itype(OP_LW, 5'd9), 0, 32'h102, 0,
          1, 5'd8, 32'd2, 1, 2'd1);
    drive("sat2_bot", 0, 0, rtype(5'd8, 5'd0), 32'd2, 0, 0, itype(OP_LW, 5'd9), 0, 32'h102, 0,
          1, 5'd9, 32'h102, 0, 2'd2);
    drive("sat3_top", 0, 0, rtype(5'd8, 5'd0), 32'd3, 0, 0, itype(OP_LW, 5'd9), 0, 32'h103, 0,
          1, 5'd8, 32'd3, 1, 2'd2);
    drive("sat3_bot", 0, 0, rtype(5'd8, 5'd0), 32'd3, 0, 0, itype(OP_LW, 5'd9), 0, 32'h103, 0,
          1, 5'd9, 32'h103, 0, 2'd3);
    drive("sat4_top", 0, 0, rtype(5'd8, 5'd0), 32'd4, 0, 0, itype(OP_LW, 5'd9), 0, 32'h104, 0,
          1, 5'd8, 32'd4, 1, 2'd3);
    drive("sat4_bot", 0, 0, rtype(5'd8, 5'd0), 32'd4, 0, 0, itype(OP_LW, 5'd9), 0, 32'h104, 0,
          1, 5'd9, 32'h104, 0, 2'd3);
    drive("idle_end", 0, 0, NOP, 0, 0, 0, NOP, 0, 0, 0,
          0, 0, 0, 0, 2'd3);
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_write_serializer.md
Name: wb_write_serializer

Overview:
- Writeback-stage consumer of the dual-issue M/W pipeline register: takes the top (older) and bottom (younger) instruction slots with their ALU result (O), memory data (D) and overflow flag, and drives the single register-file write port.
- When both slots need a register write to different destinations, it writes top in the first cycle and buffers bottom internally. It writes bottom in the following cycle, and asserts a one-cycle stall so that M/W and the upstream stages hold.

Parameters:
- RSTATUS_REG, 30, destination register for overflow status and setx
- LINK_REG, 31, destination register for jal
- CNT_W, 16, width of the saturating dual-write stall counter

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- instruction_in_top  in  32  top-slot instruction from M/W
- dataO_top  in  32  top-slot ALU result / link value
- dataD_top  in  32  top-slot memory read data
- ovf_in_top  in  1  top-slot overflow flag
- instruction_in_bot, dataO_bot, dataD_bot, ovf_in_bot  in  32/32/32/1  same meanings for the bottom slot
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  32  register-file write data
- wb_stall  out  1  high: M/W and upstream must not advance this edge (drives M/W we = ~wb_stall)
- stall_count  out  CNT_W  number of dual-write stall cycles, saturating

Behaviour:
- Decode per slot: opcode = instr[31:27], rd = instr[26:22], aluop = instr[6:2].
- Slot writes, and the value written, are decided as follows:
  - R-type 00000: rd <= O.
  - addi 00101: rd <= O.
  - lw 01000: rd <= D.
  - jal 00011: LINK_REG <= O.
  - setx 10101: RSTATUS_REG <= zero-extended instr[26:0].
  - All other opcodes do not write.
- Overflow override: if ovf=1 on R-type add (aluop 00000), addi, R-type sub (00001), mul (00110) or div (00111), the destination becomes RSTATUS_REG and the data becomes 1, 2, 3, 4 or 5 respectively.
- Any write whose final destination is r0 is suppressed (the slot is treated as not writing).
- Write-port outputs are combinational from the current state and inputs. There is no added latency in IDLE.
- FSM states: IDLE, DRAIN.
- IDLE:
  - Neither slot writes: rf_we=0.
  - Only one slot writes: that slot drives the port.
  - Both slots write to the same final destination: write bottom only (younger wins), no stall.
  - Both slots write to different destinations: write top, assert wb_stall=1, capture bottom's waddr/wdata in the hold register, go to DRAIN, and increment stall_count unless it is saturated.
- DRAIN:
  - Drive rf_we=1 with the held waddr/wdata, wb_stall=0, then return to IDLE.
  - M/W inputs are ignored in this cycle. They still hold the same pair because the previous edge was stalled.
- wb_stall is never high in two consecutive cycles.
- Reset (asynchronous): state=IDLE, hold register=0, stall_count=0. While reset is asserted, rf_we=0 and wb_stall=0.
  - If reset is asserted during DRAIN, the buffered bottom write is discarded.
- stall_count saturates at all-ones. It never wraps.

Test Plan:
- Top add r3 (O=7), bottom lw r4 (D=9) -> cycle 1: we=1, waddr=3, wdata=7, wb_stall=1. Cycle 2: we=1, waddr=4, wdata=9, wb_stall=0. stall_count=1.
- Top addi r5 (O=1), bottom add r5 (O=2) -> a single cycle with waddr=5, wdata=2, no stall.
- Top sub with ovf_in_top=1, bottom a nop -> waddr=30, wdata=3, no stall. Top addi to r0 with bottom jal (O=0x40) -> waddr=31, wdata=0x40, no stall.
- Top setx T=0x123, bottom mul r6 with ovf_in_bot=1 -> both target r30, so bottom wins: waddr=30, wdata=4, no stall.
- Dual write to r1/r2, reset pulsed mid-cycle in DRAIN -> outputs go to 0 immediately. After release the state is IDLE, rf_we=0 and stall_count=0.
- Back-to-back dual-write pairs with CNT_W=2 for four pairs -> wb_stall alternates 1,0,1,0,... and stall_count reads 1, 2, 3, 3 (saturated).
